// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: constants shared by the hazard controller and its bench.
//   state_t    : control FSM state encoding (IDLE / LD_STALL / MD_BUSY)
//   FWD_*      : operand-select codes driven on fwd_a / fwd_b
//   LAT_W      : width of the stall/occupancy down-counter (holds up to 15)
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MD_BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM result

    localparam int LAT_W = 4;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// fwd_select: bypass-source selection for one EX operand.
//   i_ex_src       : source register of the instruction in EX
//   i_mem_rd/_regwrite : EX/MEM writer
//   i_wb_rd/_regwrite  : MEM/WB writer
//   o_fwd          : FWD_MEM, FWD_WB or FWD_NONE
// The younger EX/MEM result wins over MEM/WB; register 0 is never bypassed.
// With FWD_EN = 0 the output is tied to FWD_NONE and hazards are stalled instead.
module fwd_select
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int FWD_EN   = 1
) (
    input  logic [REG_BITS-1:0] i_ex_src,
    input  logic [REG_BITS-1:0] i_mem_rd,
    input  logic                i_mem_regwrite,
    input  logic [REG_BITS-1:0] i_wb_rd,
    input  logic                i_wb_regwrite,
    output logic [1:0]          o_fwd
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_src);
    assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_src);

    always_comb begin
        o_fwd = FWD_NONE;
        if (FWD_EN != 0) begin
            if (w_mem_hit)
                o_fwd = FWD_MEM;
            else if (w_wb_hit)
                o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   id_*                  : sources of the instruction in IF/ID
//   ex_*                  : ID/EX destination/controls and sources (for bypass)
//   mem_*, wb_*           : EX/MEM and MEM/WB writers
//   branch_taken          : taken branch resolved in EX
//   pc_write, if_id_write : front-end register enables
//   id_ex_bubble, ex_hold : insert bubble into ID/EX / freeze ID/EX and EX
//   if_id_flush, id_ex_flush : squash on taken branch
//   fwd_a, fwd_b          : operand bypass selects
//   md_busy, stall_cnt    : multi-cycle busy flag, saturating stall counter
//   dbg_state             : current FSM state (debug visibility)
// Branches are not expected while a mul/div occupies EX; that is asserted.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic                ex_md_start,
    input  logic [REG_BITS-1:0] ex_rs,
    input  logic [REG_BITS-1:0] ex_rt,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_regwrite,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                id_ex_bubble,
    output logic                ex_hold,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                md_busy,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [1:0]          dbg_state
);

    state_t           r_state;
    logic [LAT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic             w_ex_match;
    logic             w_mem_match;
    logic             w_load_use;
    logic             w_raw_stall;
    logic             w_stall;

    // ---------------- bypass selection ----------------
    fwd_select #(.REG_BITS(REG_BITS), .FWD_EN(FWD_EN)) u_fwd_a (
        .i_ex_src       (ex_rs),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .o_fwd          (fwd_a)
    );

    fwd_select #(.REG_BITS(REG_BITS), .FWD_EN(FWD_EN)) u_fwd_b (
        .i_ex_src       (ex_rt),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .o_fwd          (fwd_b)
    );

    // ---------------- hazard detection ----------------
    assign w_ex_match  = ex_regwrite && (ex_rd != '0) &&
                         ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign w_mem_match = mem_regwrite && (mem_rd != '0) &&
                         ((id_use_rs && (id_rs == mem_rd)) || (id_use_rt && (id_rt == mem_rd)));
    assign w_load_use  = ex_memread && w_ex_match;
    // Without bypassing, any in-flight writer ahead of WB blocks the reader;
    // WB itself is covered by write-before-read in the register file.
    assign w_raw_stall = (FWD_EN == 0) && (w_ex_match || w_mem_match);
    // A mul/div entering EX takes precedence over any stall request.
    assign w_stall     = (w_load_use || w_raw_stall) && !ex_md_start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (ex_md_start) begin
                    w_state_nxt = ST_MD_BUSY;
                    w_cnt_nxt   = LAT_W'(MD_LAT - 1);
                end else if (!branch_taken && w_load_use && (LOAD_LAT > 1)) begin
                    w_state_nxt = ST_LD_STALL;
                    w_cnt_nxt   = LAT_W'(LOAD_LAT - 1);
                end
            end
            ST_LD_STALL: begin
                if (branch_taken || (r_cnt <= LAT_W'(1))) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_MD_BUSY: begin
                if (r_cnt <= LAT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        md_busy      = 1'b0;
        case (r_state)
            ST_MD_BUSY: begin
                md_busy     = 1'b1;
                ex_hold     = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            ST_LD_STALL: begin
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            default: begin
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_stall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        endcase
    end

    // ---------------- saturating stall counter ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (!pc_write && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cnt = r_stall_cnt;
    assign dbg_state = r_state;

    a_no_branch_in_md: assert property (@(posedge clock) disable iff (reset)
        !((r_state == ST_MD_BUSY) && branch_taken));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share the stimulus:
//   [0] LOAD_LAT=2, FWD_EN=1   [1] LOAD_LAT=3, FWD_EN=1   [2] LOAD_LAT=1, FWD_EN=0, CNT_W=3
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_md_start;
    logic       mem_regwrite, wb_regwrite, branch_taken;

    logic        pc_write [3];
    logic        if_id_write [3];
    logic        id_ex_bubble [3];
    logic        ex_hold [3];
    logic        if_id_flush [3];
    logic        id_ex_flush [3];
    logic [1:0]  fwd_a [3];
    logic [1:0]  fwd_b [3];
    logic        md_busy [3];
    logic [1:0]  dbg_state [3];
    logic [15:0] stall_cnt_ab [2];
    logic [2:0]  stall_cnt_c;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    hazard_ctrl #(.LOAD_LAT(2), .MD_LAT(4), .FWD_EN(1)) u_dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_md_start(ex_md_start), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
        .pc_write(pc_write[0]), .if_id_write(if_id_write[0]), .id_ex_bubble(id_ex_bubble[0]),
        .ex_hold(ex_hold[0]), .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .md_busy(md_busy[0]),
        .stall_cnt(stall_cnt_ab[0]), .dbg_state(dbg_state[0])
    );

    hazard_ctrl #(.LOAD_LAT(3), .MD_LAT(4), .FWD_EN(1)) u_dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_md_start(ex_md_start), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
        .pc_write(pc_write[1]), .if_id_write(if_id_write[1]), .id_ex_bubble(id_ex_bubble[1]),
        .ex_hold(ex_hold[1]), .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .md_busy(md_busy[1]),
        .stall_cnt(stall_cnt_ab[1]), .dbg_state(dbg_state[1])
    );

    hazard_ctrl #(.LOAD_LAT(1), .MD_LAT(4), .FWD_EN(0), .CNT_W(3)) u_dut_c (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_md_start(ex_md_start), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
        .pc_write(pc_write[2]), .if_id_write(if_id_write[2]), .id_ex_bubble(id_ex_bubble[2]),
        .ex_hold(ex_hold[2]), .if_id_flush(if_id_flush[2]), .id_ex_flush(id_ex_flush[2]),
        .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .md_busy(md_busy[2]),
        .stall_cnt(stall_cnt_c), .dbg_state(dbg_state[2])
    );

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_md_start = 1'b0;
        ex_rs = '0; ex_rt = '0;
        mem_rd = '0; mem_regwrite = 1'b0;
        wb_rd = '0; wb_regwrite = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();
        next_cycle();
        #1;

        // Reset state with idle inputs
        check("rst_pc_write", 32'(pc_write[0]), 32'd1);
        check("rst_md_busy", 32'(md_busy[0]), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt_ab[0]), 32'd0);
        check("rst_stall_cnt_c", 32'(stall_cnt_c), 32'd0);
        check("rst_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        do_reset();

        // Forwarding: add $3 in MEM, sub reading $3 in EX
        ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
        ex_rt = 5'd7; wb_rd = 5'd7; wb_regwrite = 1'b1;
        #1;
        check("fwd_a_mem", 32'(fwd_a[0]), 32'b10);
        check("fwd_b_wb", 32'(fwd_b[0]), 32'b01);
        check("fwd_a_nofwd_cfg", 32'(fwd_a[2]), 32'b00);
        wb_rd = 5'd3;
        #1;
        check("fwd_a_mem_over_wb", 32'(fwd_a[0]), 32'b10);
        mem_regwrite = 1'b0;
        #1;
        check("fwd_a_wb_only", 32'(fwd_a[0]), 32'b01);
        ex_rs = 5'd0; mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd0;
        #1;
        check("fwd_a_reg0", 32'(fwd_a[0]), 32'b00);
        ex_rt = 5'd7; wb_regwrite = 1'b0;
        #1;
        check("fwd_b_no_write", 32'(fwd_b[0]), 32'b00);

        // Load-use, LOAD_LAT=2 (inst 0) and LOAD_LAT=1 (inst 2)
        do_reset();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        check("ld_c1_pc_write", 32'(pc_write[0]), 32'd0);
        check("ld_c1_if_id_write", 32'(if_id_write[0]), 32'd0);
        check("ld_c1_bubble", 32'(id_ex_bubble[0]), 32'd1);
        check("ld_lat1_c1_pc_write", 32'(pc_write[2]), 32'd0);
        next_cycle();
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;  // bubble now in EX
        #1;
        check("ld_c2_state", 32'(dbg_state[0]), 32'(ST_LD_STALL));
        check("ld_c2_pc_write", 32'(pc_write[0]), 32'd0);
        check("ld_c2_bubble", 32'(id_ex_bubble[0]), 32'd1);
        check("ld_lat1_c2_pc_write", 32'(pc_write[2]), 32'd1);
        next_cycle();
        #1;
        check("ld_c3_pc_write", 32'(pc_write[0]), 32'd1);
        check("ld_c3_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        check("ld_stall_cnt", 32'(stall_cnt_ab[0]), 32'd2);
        // Load to $0 never stalls
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        check("ld_reg0_pc_write", 32'(pc_write[0]), 32'd1);

        // Multi-cycle op, MD_LAT=4
        do_reset();
        ex_md_start = 1'b1;
        #1;
        check("md_start_busy", 32'(md_busy[0]), 32'd0);
        next_cycle();
        ex_md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("md_busy", 32'(md_busy[0]), 32'd1);
            check("md_ex_hold", 32'(ex_hold[0]), 32'd1);
            check("md_pc_write", 32'(pc_write[0]), 32'd0);
            check("md_bubble", 32'(id_ex_bubble[0]), 32'd0);
            next_cycle();
        end
        #1;
        check("md_done_busy", 32'(md_busy[0]), 32'd0);
        check("md_done_hold", 32'(ex_hold[0]), 32'd0);
        check("md_done_pc_write", 32'(pc_write[0]), 32'd1);
        check("md_stall_cnt", 32'(stall_cnt_ab[0]), 32'd3);

        // Branch during load stall, LOAD_LAT=3 (inst 1)
        do_reset();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rt = 5'd5; id_use_rt = 1'b1;
        #1;
        check("lb_c1_pc_write", 32'(pc_write[1]), 32'd0);
        next_cycle();
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        branch_taken = 1'b1;
        #1;
        check("lb_c2_state", 32'(dbg_state[1]), 32'(ST_LD_STALL));
        check("lb_c2_if_id_flush", 32'(if_id_flush[1]), 32'd1);
        check("lb_c2_id_ex_flush", 32'(id_ex_flush[1]), 32'd1);
        check("lb_c2_pc_write", 32'(pc_write[1]), 32'd1);
        check("lb_c2_if_id_write", 32'(if_id_write[1]), 32'd1);
        next_cycle();
        branch_taken = 1'b0;
        #1;
        check("lb_c3_state", 32'(dbg_state[1]), 32'(ST_IDLE));
        check("lb_c3_pc_write", 32'(pc_write[1]), 32'd1);
        check("lb_stall_cnt", 32'(stall_cnt_ab[1]), 32'd1);
        // Branch and load-use together: flush wins
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; branch_taken = 1'b1;
        #1;
        check("lb_prio_pc_write", 32'(pc_write[1]), 32'd1);
        check("lb_prio_flush", 32'(if_id_flush[1]), 32'd1);
        check("lb_prio_bubble", 32'(id_ex_bubble[1]), 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        check("lb_prio_state", 32'(dbg_state[1]), 32'(ST_IDLE));

        // Mul/div start with load-use together, then reset mid-MD
        do_reset();
        ex_md_start = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rs = 5'd5; id_use_rs = 1'b1;
        next_cycle();
        clear_inputs();
        #1;
        check("mdld_state", 32'(dbg_state[0]), 32'(ST_MD_BUSY));
        next_cycle();
        #1;
        check("mdrst_busy_before", 32'(md_busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("mdrst_busy", 32'(md_busy[0]), 32'd0);
        check("mdrst_stall_cnt", 32'(stall_cnt_ab[0]), 32'd0);
        check("mdrst_pc_write", 32'(pc_write[0]), 32'd1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        #1;
        check("mdrst_after_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        check("mdrst_after_busy", 32'(md_busy[0]), 32'd0);

        // No bypassing: add $4 then dependent or (inst 2)
        do_reset();
        ex_rd = 5'd4; ex_regwrite = 1'b1;
        id_rs = 5'd4; id_use_rs = 1'b1;
        #1;
        check("nf_c1_pc_write", 32'(pc_write[2]), 32'd0);
        check("nf_c1_bubble", 32'(id_ex_bubble[2]), 32'd1);
        check("nf_c1_fwd_cfg_pc", 32'(pc_write[0]), 32'd1);
        next_cycle();
        ex_rd = 5'd0; ex_regwrite = 1'b0;
        mem_rd = 5'd4; mem_regwrite = 1'b1; ex_rs = 5'd4;
        #1;
        check("nf_c2_pc_write", 32'(pc_write[2]), 32'd0);
        check("nf_c2_fwd_a", 32'(fwd_a[2]), 32'b00);
        check("nf_c2_fwd_a_en", 32'(fwd_a[0]), 32'b10);
        next_cycle();
        mem_rd = 5'd0; mem_regwrite = 1'b0;
        wb_rd = 5'd4; wb_regwrite = 1'b1;
        #1;
        check("nf_c3_pc_write", 32'(pc_write[2]), 32'd1);
        check("nf_c3_fwd_a", 32'(fwd_a[2]), 32'b00);
        check("nf_stall_cnt", 32'(stall_cnt_c), 32'd2);

        // Saturation of a 3-bit stall counter
        do_reset();
        ex_rd = 5'd6; ex_regwrite = 1'b1;
        id_rs = 5'd6; id_use_rs = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
        #1;
        check("sat_stall_cnt", 32'(stall_cnt_c), 32'd7);
        check("sat_pc_write", 32'(pc_write[2]), 32'd0);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
